// File: rtl/processor_project_pkg.sv
// Shared definitions for the processor_project core: opcodes, CZ condition codes,
// the pipeline stage-register payload and small decode helpers.
package processor_project_pkg;

    localparam int unsigned XLEN = 16;
    localparam int unsigned RIDX = 3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    localparam logic [1:0] CZ_ALWAYS = 2'b00;
    localparam logic [1:0] CZ_IFZ    = 2'b01;
    localparam logic [1:0] CZ_IFC    = 2'b10;
    localparam logic [1:0] CZ_NOP    = 2'b11;

    // One pipeline register; every stage boundary carries the same payload.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] opa;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] result;
        logic [RIDX-1:0] dest;
        logic            wr_en;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    function automatic logic [XLEN-1:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    // Which register fields an opcode actually reads (for load-use detection).
    function automatic logic uses_ra(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADI) || (op == OP_NDU) ||
               (op == OP_SW)  || (op == OP_BEQ);
    endfunction

    function automatic logic uses_rb(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_NDU) || (op == OP_LW) ||
               (op == OP_SW)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/processor_project_data_mem.sv
// DM_DEPTH x 16 data memory: combinational read, write at the clock edge.
// The word address wraps modulo DM_DEPTH.
// Ports: clk; addr; rdata_c; we/wdata write port.
module data_mem #(
    parameter int unsigned DM_DEPTH = 256
) (
    input  logic        clk,
    input  logic [15:0] addr,
    output logic [15:0] rdata_c,
    input  logic        we,
    input  logic [15:0] wdata
);
    localparam int unsigned AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    logic [15:0]   DM [0:DM_DEPTH-1];
    logic [AW-1:0] idx_c;

    assign idx_c = AW'(32'(addr) % DM_DEPTH);

    always_ff @(posedge clk) begin
        if (we) DM[idx_c] <= wdata;
    end

    assign rdata_c = DM[idx_c];
endmodule

// File: rtl/processor_project_instr_mem.sv
// 64K x 16 instruction memory with combinational read.
// The write port exists for completeness; the core ties it off and images are preloaded.
// Ports: clk; addr/rdata_c fetch port; we/waddr/wdata write port.
module instr_mem (
    input  logic        clk,
    input  logic [15:0] addr,
    output logic [15:0] rdata_c,
    input  logic        we,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata
);
    logic [15:0] IM [0:65535];

    always_ff @(posedge clk) begin
        if (we) IM[waddr] <= wdata;
    end

    assign rdata_c = IM[addr];
endmodule

// File: rtl/processor_project_register_file.sv
// 8 x 16 register file: two combinational read ports, one write port.
// A same-cycle write to the register being read is bypassed to the read data.
// Ports: clk; ra1/ra2 read addresses; rd1_c/rd2_c read data; we/wa/wd write port.
module register_file (
    input  logic        clk,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    output logic [15:0] rd1_c,
    output logic [15:0] rd2_c,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd
);
    logic [15:0] RF [0:7];

    always_ff @(posedge clk) begin
        if (we) RF[wa] <= wd;
    end

    assign rd1_c = (we && (wa == ra1)) ? wd : RF[ra1];
    assign rd2_c = (we && (wa == ra2)) ? wd : RF[ra2];
endmodule

// File: rtl/processor_project.sv
// 16-bit 8-register RISC core, 6-stage in-order pipeline IF ID RR EX MEM WB.
// RR reads the register file (with WB bypass); EX forwards from MEM and WB.
// Branches/JAL resolve in EX and squash IF/ID/RR; LW-use stalls one cycle.
// Ports: clk; rst (sync, active high); cy/z architectural flags.
module processor_project
    import processor_project_pkg::*;
#(
    parameter int unsigned DM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    output logic cy,
    output logic z
);
    logic [15:0] pc;
    stage_t      ifid, idrr, rrex, exmem, memwb;
    stage_t      if_c, id_c, rr_c, ex_c, mem_c;

    logic [15:0] im_rdata_c, rf_rd1_c, rf_rd2_c, dm_rdata_c;
    logic [15:0] a_c, b_c, add_b_c, target_c;
    logic [16:0] add_c;
    logic [3:0]  ex_op_c, rr_op_c;
    logic        cond_ok_c, exec_c, redirect_c, load_use_c, cy_n, z_n;
    logic        rf_we_c, dm_we_c;
    logic        unused_wb_fields;

    instr_mem IM1 (
        .clk(clk), .addr(pc), .rdata_c(im_rdata_c),
        .we(1'b0), .waddr(16'h0000), .wdata(16'h0000)
    );

    register_file RF1 (
        .clk(clk), .ra1(idrr.instr[11:9]), .ra2(idrr.instr[8:6]),
        .rd1_c(rf_rd1_c), .rd2_c(rf_rd2_c),
        .we(rf_we_c), .wa(memwb.dest), .wd(memwb.result)
    );

    data_mem #(.DM_DEPTH(DM_DEPTH)) DM1 (
        .clk(clk), .addr(exmem.result), .rdata_c(dm_rdata_c),
        .we(dm_we_c), .wdata(exmem.opa)
    );

    // IF: capture the fetched word with its pc.
    always_comb begin
        if_c       = BUBBLE;
        if_c.valid = 1'b1;
        if_c.pc    = pc;
        if_c.instr = im_rdata_c;
    end

    // ID: destination register and tentative write enable; R7 writes are dropped.
    always_comb begin
        id_c       = ifid;
        id_c.dest  = '0;
        id_c.wr_en = 1'b0;
        case (ifid.instr[15:12])
            OP_ADD, OP_NDU: begin
                id_c.dest  = ifid.instr[5:3];
                id_c.wr_en = (ifid.instr[1:0] != CZ_NOP);
            end
            OP_ADI: begin
                id_c.dest  = ifid.instr[8:6];
                id_c.wr_en = 1'b1;
            end
            OP_LHI, OP_LW, OP_JAL: begin
                id_c.dest  = ifid.instr[11:9];
                id_c.wr_en = 1'b1;
            end
            default: ;
        endcase
        if (id_c.dest == 3'd7) id_c.wr_en = 1'b0;
    end

    // RR: operand read; R7 reads as the instruction's own pc.
    always_comb begin
        rr_c     = idrr;
        rr_op_c  = idrr.instr[15:12];
        rr_c.opa = (idrr.instr[11:9] == 3'd7) ? idrr.pc : rf_rd1_c;
        rr_c.opb = (idrr.instr[8:6]  == 3'd7) ? idrr.pc : rf_rd2_c;
    end

    // LW in EX feeding the instruction in RR: hold front end, bubble into EX.
    always_comb begin
        load_use_c = rrex.valid && rrex.wr_en && (rrex.instr[15:12] == OP_LW) && idrr.valid &&
                     ((uses_ra(rr_op_c) && (idrr.instr[11:9] == rrex.dest)) ||
                      (uses_rb(rr_op_c) && (idrr.instr[8:6]  == rrex.dest)));
    end

    // EX operand forwarding; MEM is younger than WB so it is checked first.
    // A load in MEM has no data yet, which the load-use stall guarantees is never needed.
    always_comb begin
        a_c = rrex.opa;
        b_c = rrex.opb;
        if (exmem.valid && exmem.wr_en && (exmem.instr[15:12] != OP_LW) &&
            (exmem.dest == rrex.instr[11:9]))
            a_c = exmem.result;
        else if (memwb.valid && memwb.wr_en && (memwb.dest == rrex.instr[11:9]))
            a_c = memwb.result;
        if (exmem.valid && exmem.wr_en && (exmem.instr[15:12] != OP_LW) &&
            (exmem.dest == rrex.instr[8:6]))
            b_c = exmem.result;
        else if (memwb.valid && memwb.wr_en && (memwb.dest == rrex.instr[8:6]))
            b_c = memwb.result;
    end

    // EX: condition check against committed flags, ALU, branch resolution.
    always_comb begin
        ex_op_c   = rrex.instr[15:12];
        cond_ok_c = 1'b1;
        if ((ex_op_c == OP_ADD) || (ex_op_c == OP_NDU)) begin
            case (rrex.instr[1:0])
                CZ_IFC:  cond_ok_c = cy;
                CZ_IFZ:  cond_ok_c = z;
                CZ_NOP:  cond_ok_c = 1'b0;
                default: cond_ok_c = 1'b1;
            endcase
        end
        exec_c     = rrex.valid && cond_ok_c;
        add_b_c    = (ex_op_c == OP_ADI) ? sext6(rrex.instr[5:0]) : b_c;
        add_c      = {1'b0, a_c} + {1'b0, add_b_c};
        ex_c       = rrex;
        ex_c.opa   = a_c;
        ex_c.opb   = b_c;
        ex_c.result = '0;
        ex_c.wr_en = rrex.wr_en && cond_ok_c;
        cy_n       = cy;
        z_n        = z;
        redirect_c = 1'b0;
        target_c   = '0;
        case (ex_op_c)
            OP_ADD, OP_ADI: begin
                ex_c.result = add_c[15:0];
                if (exec_c) begin
                    cy_n = add_c[16];
                    z_n  = (add_c[15:0] == 16'h0000);
                end
            end
            OP_NDU: begin
                ex_c.result = ~(a_c & b_c);
                if (exec_c) z_n = ((a_c & b_c) == 16'hFFFF);
            end
            OP_LHI:        ex_c.result = {rrex.instr[8:0], 7'b0};
            OP_LW, OP_SW:  ex_c.result = b_c + sext6(rrex.instr[5:0]);
            OP_BEQ: begin
                redirect_c = rrex.valid && (a_c == b_c);
                target_c   = rrex.pc + sext6(rrex.instr[5:0]);
            end
            OP_JAL: begin
                ex_c.result = rrex.pc + 16'd1;
                redirect_c  = rrex.valid;
                target_c    = rrex.pc + sext9(rrex.instr[8:0]);
            end
            default: ;
        endcase
    end

    // MEM: load data replaces the address; stores commit at the edge.
    always_comb begin
        mem_c = exmem;
        if (exmem.instr[15:12] == OP_LW) mem_c.result = dm_rdata_c;
    end

    assign dm_we_c = exmem.valid && (exmem.instr[15:12] == OP_SW) && !rst;
    assign rf_we_c = memwb.valid && memwb.wr_en && !rst;

    // WB only consumes dest/result/enables; the rest rides along for visibility.
    assign unused_wb_fields = ^{memwb.pc, memwb.instr, memwb.opa, memwb.opb};

    // Pipeline advance: redirect beats stall; reset clears every valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ifid  <= BUBBLE;
            idrr  <= BUBBLE;
            rrex  <= BUBBLE;
            exmem <= BUBBLE;
            memwb <= BUBBLE;
            cy    <= 1'b0;
            z     <= 1'b0;
        end else begin
            cy    <= cy_n;
            z     <= z_n;
            exmem <= ex_c;
            memwb <= mem_c;
            if (redirect_c) begin
                pc   <= target_c;
                ifid <= BUBBLE;
                idrr <= BUBBLE;
                rrex <= BUBBLE;
            end else if (load_use_c) begin
                rrex <= BUBBLE;
            end else begin
                pc   <= pc + 16'd1;
                ifid <= if_c;
                idrr <= id_c;
                rrex <= rr_c;
            end
        end
    end
endmodule

// File: tb/tb_processor_project.sv
// Directed self-checking bench for processor_project. Programs are preloaded
// hierarchically while reset is held; unused instruction words are filled with
// opcode 1111 (a true NOP) because an all-zero word decodes as ADD R0,R0,R0 and
// would set z. "After edge k" means k rising edges after the reset edge.
module tb_processor_project;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cy, z;
    int   checks = 0;
    int   errors = 0;

    processor_project #(.DM_DEPTH(256)) dut (.clk(clk), .rst(rst), .cy(cy), .z(z));

    always #5 clk = ~clk;

    task automatic begin_test();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) dut.IM1.IM[i] = 16'hF000;
        for (int i = 0; i < 8; i++)  dut.RF1.RF[i] = 16'h0000;
        for (int i = 0; i < 16; i++) dut.DM1.DM[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        begin_test();
        dut.IM1.IM[0] = 16'h3201;
        release_reset();
        checks++; if (dut.pc !== 16'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", dut.pc); end
        checks++; if ({cy, z} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {cy, z}); end
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checks++; if (dut.pc !== 16'(k)) begin errors++; $display("FAIL lhi_pc edge %0d: got %h expected %h", k, dut.pc, 16'(k)); end
            checks++; if ({cy, z} !== 2'b00) begin errors++; $display("FAIL lhi_flags edge %0d: got %b expected 00", k, {cy, z}); end
            if (k == 5) begin
                checks++; if (dut.RF1.RF[1] !== 16'h0000) begin errors++; $display("FAIL lhi_early: got %h expected 0000", dut.RF1.RF[1]); end
            end
        end
        checks++; if (dut.RF1.RF[1] !== 16'h0080) begin errors++; $display("FAIL lhi_r1: got %h expected 0080", dut.RF1.RF[1]); end
    endtask

    task automatic test_cond_false();
        begin_test();
        dut.IM1.IM[0] = 16'h3201;
        dut.IM1.IM[1] = 16'h0281;
        dut.IM1.IM[2] = 16'h07C2;
        release_reset();
        step(9);
        checks++; if (dut.RF1.RF[0] !== 16'h0000) begin errors++; $display("FAIL cond_r0: got %h expected 0000", dut.RF1.RF[0]); end
        checks++; if (dut.RF1.RF[1] !== 16'h0080) begin errors++; $display("FAIL cond_r1: got %h expected 0080", dut.RF1.RF[1]); end
        checks++; if (dut.RF1.RF[2] !== 16'h0000) begin errors++; $display("FAIL cond_r2: got %h expected 0000", dut.RF1.RF[2]); end
        checks++; if (dut.RF1.RF[5] !== 16'h0000) begin errors++; $display("FAIL cond_r5: got %h expected 0000", dut.RF1.RF[5]); end
        checks++; if ({cy, z} !== 2'b00) begin errors++; $display("FAIL cond_flags: got %b expected 00", {cy, z}); end
    endtask

    task automatic test_flags();
        begin_test();
        dut.RF1.RF[1] = 16'hFFFF;
        dut.RF1.RF[2] = 16'h0001;
        dut.IM1.IM[0] = 16'h0298;   // ADD R3=R1+R2
        dut.IM1.IM[1] = 16'h0262;   // ADC R4=R1+R1
        dut.IM1.IM[2] = 16'h04A9;   // ADZ R5=R2+R2
        release_reset();
        step(4);
        checks++; if ({cy, z} !== 2'b11) begin errors++; $display("FAIL add_flags: got %b expected 11", {cy, z}); end
        step(1);
        checks++; if ({cy, z} !== 2'b10) begin errors++; $display("FAIL adc_flags: got %b expected 10", {cy, z}); end
        step(1);
        checks++; if ({cy, z} !== 2'b10) begin errors++; $display("FAIL adz_flags: got %b expected 10", {cy, z}); end
        step(2);
        checks++; if (dut.RF1.RF[3] !== 16'h0000) begin errors++; $display("FAIL add_r3: got %h expected 0000", dut.RF1.RF[3]); end
        checks++; if (dut.RF1.RF[4] !== 16'hFFFE) begin errors++; $display("FAIL adc_r4: got %h expected fffe", dut.RF1.RF[4]); end
        checks++; if (dut.RF1.RF[5] !== 16'h0000) begin errors++; $display("FAIL adz_r5: got %h expected 0000", dut.RF1.RF[5]); end
    endtask

    task automatic test_mid_reset();
        begin_test();
        dut.RF1.RF[1] = 16'hFFFF;
        dut.RF1.RF[2] = 16'h0001;
        dut.IM1.IM[0] = 16'h0298;
        dut.IM1.IM[1] = 16'h0262;   // would write R4 at edge 7
        release_reset();
        step(6);
        checks++; if (cy !== 1'b1) begin errors++; $display("FAIL midrst_pre_cy: got %b expected 1", cy); end
        rst = 1'b1;
        step(1);
        checks++; if (dut.pc !== 16'd0) begin errors++; $display("FAIL midrst_pc: got %h expected 0000", dut.pc); end
        checks++; if ({cy, z} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b expected 00", {cy, z}); end
        checks++; if (dut.RF1.RF[4] !== 16'h0000) begin errors++; $display("FAIL midrst_r4: got %h expected 0000", dut.RF1.RF[4]); end
        step(1);
        checks++; if (dut.RF1.RF[4] !== 16'h0000) begin errors++; $display("FAIL midrst_r4_hold: got %h expected 0000", dut.RF1.RF[4]); end
    endtask

    task automatic test_load_use();
        begin_test();
        dut.RF1.RF[1] = 16'h0001;
        dut.RF1.RF[2] = 16'h0005;
        dut.DM1.DM[5] = 16'h1234;
        dut.IM1.IM[0] = 16'h4880;   // LW  R4=DM[R2]
        dut.IM1.IM[1] = 16'h0870;   // ADD R6=R4+R1
        dut.IM1.IM[2] = 16'h5C81;   // SW  R6 -> DM[R2+1]
        release_reset();
        step(3);
        checks++; if (dut.pc !== 16'd3) begin errors++; $display("FAIL lu_pc3: got %h expected 0003", dut.pc); end
        step(1);
        checks++; if (dut.pc !== 16'd3) begin errors++; $display("FAIL lu_stall_pc: got %h expected 0003", dut.pc); end
        step(3);
        checks++; if (dut.RF1.RF[6] !== 16'h0000) begin errors++; $display("FAIL lu_r6_early: got %h expected 0000", dut.RF1.RF[6]); end
        step(1);
        checks++; if (dut.RF1.RF[4] !== 16'h1234) begin errors++; $display("FAIL lu_r4: got %h expected 1234", dut.RF1.RF[4]); end
        checks++; if (dut.RF1.RF[6] !== 16'h1235) begin errors++; $display("FAIL lu_r6: got %h expected 1235", dut.RF1.RF[6]); end
        checks++; if (dut.DM1.DM[6] !== 16'h1235) begin errors++; $display("FAIL lu_sw: got %h expected 1235", dut.DM1.DM[6]); end
        step(4);
        checks++; if (dut.pc !== 16'd11) begin errors++; $display("FAIL lu_pc12: got %h expected 000b", dut.pc); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_rf [8];
        begin_test();
        dut.RF1.RF[1] = 16'h0003;
        dut.IM1.IM[0] = 16'h0250;   // R2=R1+R1
        dut.IM1.IM[1] = 16'h0458;   // R3=R2+R1
        dut.IM1.IM[2] = 16'h06A0;   // R4=R3+R2
        dut.IM1.IM[3] = 16'h0528;   // R5=R2+R4
        dut.IM1.IM[4] = 16'h1BBF;   // R6=R5-1
        release_reset();
        step(9);
        checks++; if (dut.RF1.RF[6] !== 16'h0000) begin errors++; $display("FAIL b2b_r6_early: got %h expected 0000", dut.RF1.RF[6]); end
        step(1);
        exp_rf = '{16'h0000, 16'h0003, 16'h0006, 16'h0009, 16'h000F, 16'h0015, 16'h0014, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.RF1.RF[i] !== exp_rf[i]) begin errors++; $display("FAIL b2b_r%0d: got %h expected %h", i, dut.RF1.RF[i], exp_rf[i]); end
        end
        checks++; if (dut.pc !== 16'd10) begin errors++; $display("FAIL b2b_pc: got %h expected 000a", dut.pc); end
        checks++; if ({cy, z} !== 2'b10) begin errors++; $display("FAIL b2b_flags: got %b expected 10", {cy, z}); end
    endtask

    task automatic test_branch();
        begin_test();
        dut.RF1.RF[1] = 16'h0007;
        dut.RF1.RF[2] = 16'h0007;
        dut.IM1.IM[0] = 16'hC284;   // BEQ R1,R2,+4
        dut.IM1.IM[1] = 16'h12C1;   // R3=R1+1 (squashed)
        dut.IM1.IM[2] = 16'h1301;   // R4=R1+1 (squashed)
        dut.IM1.IM[3] = 16'h0028;   // R5=R0+R0 (squashed, would set z)
        dut.IM1.IM[4] = 16'h1381;   // R6=R1+1
        release_reset();
        step(3);
        checks++; if (dut.pc !== 16'd3) begin errors++; $display("FAIL beq_pc3: got %h expected 0003", dut.pc); end
        step(1);
        checks++; if (dut.pc !== 16'd4) begin errors++; $display("FAIL beq_target: got %h expected 0004", dut.pc); end
        step(1);
        checks++; if (dut.pc !== 16'd5) begin errors++; $display("FAIL beq_pc5: got %h expected 0005", dut.pc); end
        step(7);
        checks++; if (dut.RF1.RF[3] !== 16'h0000) begin errors++; $display("FAIL beq_r3: got %h expected 0000", dut.RF1.RF[3]); end
        checks++; if (dut.RF1.RF[4] !== 16'h0000) begin errors++; $display("FAIL beq_r4: got %h expected 0000", dut.RF1.RF[4]); end
        checks++; if (dut.RF1.RF[5] !== 16'h0000) begin errors++; $display("FAIL beq_r5: got %h expected 0000", dut.RF1.RF[5]); end
        checks++; if (dut.RF1.RF[6] !== 16'h0008) begin errors++; $display("FAIL beq_r6: got %h expected 0008", dut.RF1.RF[6]); end
        checks++; if ({cy, z} !== 2'b00) begin errors++; $display("FAIL beq_flags: got %b expected 00", {cy, z}); end
    endtask

    task automatic test_jal();
        begin_test();
        dut.IM1.IM[0] = 16'h8A03;   // JAL R5,+3
        dut.IM1.IM[3] = 16'h0BF0;   // R6=R5+R7 (R7 reads as 3)
        release_reset();
        step(4);
        checks++; if (dut.pc !== 16'd3) begin errors++; $display("FAIL jal_target: got %h expected 0003", dut.pc); end
        step(2);
        checks++; if (dut.RF1.RF[5] !== 16'h0001) begin errors++; $display("FAIL jal_link: got %h expected 0001", dut.RF1.RF[5]); end
        step(4);
        checks++; if (dut.RF1.RF[6] !== 16'h0004) begin errors++; $display("FAIL jal_r7_read: got %h expected 0004", dut.RF1.RF[6]); end
    endtask

    initial begin
        test_reset();
        test_cond_false();
        test_flags();
        test_mid_reset();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_jal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
